// File: rtl/uart_arb_pkg.sv
// Shared types, constants and helpers for the UART transmit arbiter.
// Optional feature macro: UART_ARB_ID_HEADER_EN (prefix each frame with an ID header byte).
package uart_arb_pkg;

    localparam int unsigned ARB_ID_W   = 3;
    localparam int unsigned ARB_BUS_W  = 256;
    localparam int unsigned ARB_LANE_W = 32;

    localparam logic [3:0] ARB_HDR_TAG = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

    // Extract lane idx of width w from a flattened lane bus (w <= ARB_LANE_W)
    function automatic logic [ARB_LANE_W-1:0] lane_sel(
        input logic [ARB_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [ARB_BUS_W-1:0]  sh;
        logic [ARB_LANE_W-1:0] mask;
        sh   = bus >> (idx * w);
        mask = (w >= ARB_LANE_W) ? '1 : ((ARB_LANE_W'(1) << w) - ARB_LANE_W'(1));
        return ARB_LANE_W'(sh) & mask;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Scan ptr_i+1 .. ptr_i+N modulo N, keep the first requester found
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                grant_o = cand;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one byte-level UART transmitter.
// Optional feature macro: UART_ARB_ID_HEADER_EN (header byte {A,0,id} ahead of each frame).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DBITS      = 8,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned LEN_BITS   = 5,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned GAP_BITS   = 5
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DBITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [DBITS-1:0]           tx_data,
    input  logic                       tx_done,
    output logic                       grant_valid,
    output logic [ARB_ID_W-1:0]        grant_id,
    output logic                       overrun
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     gid_q, gid_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 gv_q, gv_d;
    logic [LEN_BITS-1:0]  byte_cnt_q, byte_cnt_d;
    logic [GAP_BITS-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DBITS-1:0]     tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 overrun_q, overrun_d;
    logic                 last_q, last_d;
`ifdef UART_ARB_ID_HEADER_EN
    logic                 hdr_q, hdr_d;
`endif

    logic [IDX_W-1:0]     arb_gid_c;
    logic                 arb_any_c;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_gid_c),
        .any_o   (arb_any_c)
    );

    // Next-state and registered-output logic for the frame FSM
    always_comb begin
        state_d     = state_q;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        gv_d        = gv_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        overrun_d   = 1'b0;
`ifdef UART_ARB_ID_HEADER_EN
        hdr_d       = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    gid_d      = arb_gid_c;
                    gv_d       = 1'b1;
                    byte_cnt_d = '0;
                    last_d     = 1'b0;
`ifdef UART_ARB_ID_HEADER_EN
                    tx_data_d  = DBITS'({ARB_HDR_TAG, 1'b0, 3'(arb_gid_c)});
                    tx_start_d = 1'b1;
                    hdr_d      = 1'b1;
                    state_d    = ST_START;
`else
                    state_d    = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                if (req_valid[gid_q]) begin
                    req_ready_d[gid_q] = 1'b1;
                    tx_data_d  = DBITS'(lane_sel(ARB_BUS_W'(req_data), 32'(gid_q), DBITS));
                    last_d     = req_last[gid_q];
                    byte_cnt_d = byte_cnt_q + LEN_BITS'(1);
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
`ifdef UART_ARB_ID_HEADER_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else
`endif
                    if (last_q || (byte_cnt_q == LEN_BITS'(MAX_LEN))) begin
                        overrun_d = ~last_q;
                        ptr_d     = gid_q;
                        gv_d      = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_BITS'(GAP_CYCLES)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gid_q       <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gv_q        <= 1'b0;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            overrun_q   <= 1'b0;
            last_q      <= 1'b0;
`ifdef UART_ARB_ID_HEADER_EN
            hdr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gid_q       <= gid_d;
            ptr_q       <= ptr_d;
            gv_q        <= gv_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            overrun_q   <= overrun_d;
            last_q      <= last_d;
`ifdef UART_ARB_ID_HEADER_EN
            hdr_q       <= hdr_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_valid = gv_q;
    assign grant_id    = ARB_ID_W'(gid_q);
    assign overrun     = overrun_q;

endmodule
